// File: rtl/pp_row_sequencer.sv
// pp_row_sequencer: takes one unsigned operand pair and emits one aligned,
// zero-extended partial-product row per clock to the CSA stage. A shadow
// accumulator sums the rows, and the finished product is held on a
// valid/ready port until the consumer takes it.
module pp_row_sequencer #(
    parameter int WIDTH     = 4,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_a_i,
    input  logic [WIDTH-1:0]           in_b_i,
    output logic                       row_valid_o,
    output logic [2*WIDTH-1:0]         row_data_o,
    output logic [$clog2(WIDTH)-1:0]   row_idx_o,
    output logic                       row_last_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [2*WIDTH-1:0]         out_prod_o,
    output logic                       busy_o
);
    localparam int PW = 2 * WIDTH;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ROW, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d, prod_q, prod_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic            row_bit;
    logic            last_c;
    logic [PW-1:0]   row_c;

    // Current row is built from the latched operands only, so the row
    // outputs never depend combinationally on the input port.
    always_comb begin
        row_bit = b_q[idx_q];
        last_c  = (idx_q == IW'(WIDTH - 1));
        row_c   = PW'(a_q & {WIDTH{row_bit}}) << idx_q;
    end

    // Next-state and datapath updates; in_ready is registered from the next
    // state so it stays low through reset and rises one cycle after release.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        prod_d  = prod_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i && in_ready_q) begin
                    a_d     = in_a_i;
                    b_d     = in_b_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_ROW;
                end
            end
            S_ROW: begin
                acc_d = acc_q + row_c;
                if (last_c) begin
                    prod_d  = acc_q + row_c;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Operand, accumulator, row index and product registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            prod_q <= prod_d;
        end
    end

    // Outputs decoded from state and registers only.
    always_comb begin
        in_ready_o  = in_ready_q;
        row_valid_o = (state_q == S_ROW) && (SKIP_ZERO ? row_bit : 1'b1);
        row_data_o  = (state_q == S_ROW) ? row_c : '0;
        row_idx_o   = idx_q;
        row_last_o  = (state_q == S_ROW) && last_c;
        out_valid_o = (state_q == S_DONE);
        out_prod_o  = prod_q;
        busy_o      = (state_q != S_IDLE);
    end
endmodule

// File: tb/tb_pp_row_sequencer.sv
// Bench for pp_row_sequencer: two instances (SKIP_ZERO=0 and 1) share the
// same stimulus; rows and product are checked against an arithmetic model.
module tb_pp_row_sequencer;
    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready;
    logic [3:0] in_a, in_b;

    logic       ir0, rv0, rl0, ov0, bz0, ir1, rv1, rl1, ov1, bz1;
    logic [7:0] rd0, op0, rd1, op1;
    logic [1:0] ri0, ri1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] rows [4];
        logic [7:0] prod;
        int         hold;
    } vec_t;

    vec_t tbl [5];

    pp_row_sequencer #(.WIDTH(4), .SKIP_ZERO(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir0),
        .in_a_i(in_a), .in_b_i(in_b), .row_valid_o(rv0), .row_data_o(rd0),
        .row_idx_o(ri0), .row_last_o(rl0), .out_valid_o(ov0),
        .out_ready_i(out_ready), .out_prod_o(op0), .busy_o(bz0));

    pp_row_sequencer #(.WIDTH(4), .SKIP_ZERO(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(ir1),
        .in_a_i(in_a), .in_b_i(in_b), .row_valid_o(rv1), .row_data_o(rd1),
        .row_idx_o(ri1), .row_last_o(rl1), .out_valid_o(ov1),
        .out_ready_i(out_ready), .out_prod_o(op1), .busy_o(bz1));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Spec-level model: row k is a<<k when b[k] is set, product is a*b.
    function automatic vec_t model(input logic [3:0] a, input logic [3:0] b, input int hold);
        vec_t v;
        v.a = a;
        v.b = b;
        for (int k = 0; k < 4; k++) v.rows[k] = b[k] ? (8'(a) << k) : 8'd0;
        v.prod = 8'(a) * 8'(b);
        v.hold = hold;
        return v;
    endfunction

    task automatic chk_idle_zero(input string nm);
        chk({nm, "_in_ready"}, {ir0, ir1}, 2'b00);
        chk({nm, "_row_valid"}, {rv0, rv1}, 2'b00);
        chk({nm, "_row_last"}, {rl0, rl1}, 2'b00);
        chk({nm, "_out_valid"}, {ov0, ov1}, 2'b00);
        chk({nm, "_busy"}, {bz0, bz1}, 2'b00);
        chk({nm, "_row_data"}, {rd0, rd1}, 16'h0);
        chk({nm, "_out_prod"}, {op0, op1}, 16'h0);
    endtask

    // One full operation: accept, WIDTH row cycles, DONE held for v.hold
    // cycles (with unrelated in_valid traffic), then the output handshake.
    task automatic run_op(input vec_t v, input bit noisy);
        int n = 0;
        while (!ir0 && n < 20) begin
            step();
            n++;
        end
        chk("accept_wait", ir0, 1'b1);
        in_a = v.a;
        in_b = v.b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("row_valid0", rv0, 1'b1);
            chk("row_valid1", rv1, v.b[k]);
            chk("row_data0", rd0, v.rows[k]);
            chk("row_data1", rd1, v.rows[k]);
            chk("row_idx", {ri0, ri1}, {2'(k), 2'(k)});
            chk("row_last", {rl0, rl1}, {2{k == 3}});
            chk("row_busy", {bz0, bz1}, 2'b11);
            chk("row_in_ready", {ir0, ir1}, 2'b00);
            chk("row_out_valid", {ov0, ov1}, 2'b00);
            if (noisy) begin
                out_ready = 1'($urandom);
                in_valid  = 1'($urandom);
                in_a      = 4'($urandom);
                in_b      = 4'($urandom);
            end
            step();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        for (int d = 0; d < v.hold; d++) begin
            chk("done_out_valid", {ov0, ov1}, 2'b11);
            chk("done_out_prod0", op0, v.prod);
            chk("done_out_prod1", op1, v.prod);
            chk("done_in_ready", {ir0, ir1}, 2'b00);
            chk("done_row_valid", {rv0, rv1}, 2'b00);
            in_valid = 1'b1;
            in_a = 4'($urandom);
            in_b = 4'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("hs_out_valid", {ov0, ov1}, 2'b11);
        chk("hs_out_prod", {op0, op1}, {v.prod, v.prod});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_out_valid", {ov0, ov1}, 2'b00);
        chk("post_in_ready", {ir0, ir1}, 2'b11);
        chk("post_busy", {bz0, bz1}, 2'b00);
        chk("post_out_prod", {op0, op1}, {v.prod, v.prod});
    endtask

    initial begin
        tbl[0] = '{a: 4'd13, b: 4'd11, rows: '{8'd13, 8'd26, 8'd0, 8'd104}, prod: 8'd143, hold: 0};
        tbl[1] = '{a: 4'd15, b: 4'd15, rows: '{8'd15, 8'd30, 8'd60, 8'd120}, prod: 8'd225, hold: 1};
        tbl[2] = '{a: 4'd9,  b: 4'd0,  rows: '{8'd0, 8'd0, 8'd0, 8'd0}, prod: 8'd0, hold: 0};
        tbl[3] = '{a: 4'd0,  b: 4'd7,  rows: '{8'd0, 8'd0, 8'd0, 8'd0}, prod: 8'd0, hold: 2};
        tbl[4] = '{a: 4'd5,  b: 4'd6,  rows: '{8'd0, 8'd10, 8'd20, 8'd0}, prod: 8'd30, hold: 6};

        // Reset with in_valid high: rst wins, nothing captured.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_a = 4'd5; in_b = 4'd5;
        step();
        step();
        chk_idle_zero("reset");
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rel_in_ready_low", ir0, 1'b0);
        step();
        chk("rel_in_ready", {ir0, ir1}, 2'b11);
        chk("rel_busy", {bz0, bz1}, 2'b00);

        // Spec vectors, including a 6-cycle out_ready stall with in_valid.
        foreach (tbl[i]) run_op(tbl[i], 1'b0);

        // rst during cycle 2 of ROW abandons the operation.
        in_a = 4'd7; in_b = 4'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("abort_row0", rd0, 8'd7);
        step();
        chk("abort_row1_idx", ri0, 2'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_zero("abort");
        for (int c = 0; c < 6; c++) begin
            step();
            chk("abort_in_ready", {ir0, ir1}, 2'b11);
            chk("abort_quiet", {rv0, rv1, ov0, ov1, bz0, bz1}, 6'b0);
        end
        run_op(model(4'd6, 4'd3, 0), 1'b0);

        // Random operands against the model, with noise on the handshakes.
        for (int r = 0; r < 30; r++)
            run_op(model(4'($urandom), 4'($urandom), int'($urandom_range(0, 3))), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
